pingpong_buffer_ctrl: RTL and testbench

//   Ping-pong sequencer for the two 32x8 frame RAMs that sit between the beat-data generator and the VGA sampler.
//   One bank is filled from the producer stream while the other is drained to the consumer.

---
 rtl/pingpong_buffer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pingpong_buffer_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buffer_ctrl.sv
// Ping-pong controller for two frame RAMs: fills one bank from the producer stream while
// the other is drained to the consumer, swapping only on whole-frame boundaries.
module pingpong_buffer_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_req,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              ram0_we,
    output logic [ADDR_W-1:0] ram0_waddr,
    output logic [DATA_W-1:0] ram0_wdata,
    output logic              ram0_re,
    output logic [ADDR_W-1:0] ram0_raddr,
    input  logic [DATA_W-1:0] ram0_rdata,
    output logic              ram1_we,
    output logic [ADDR_W-1:0] ram1_waddr,
    output logic [DATA_W-1:0] ram1_wdata,
    output logic              ram1_re,
    output logic [ADDR_W-1:0] ram1_raddr,
    input  logic [DATA_W-1:0] ram1_rdata,
    output logic [1:0]        full_mask,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_TAIL} rd_st_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bank_st_e [1:0]    bank_q, bank_n;
    rd_st_e            rd_state_q, rd_state_n;
    logic              wr_bank_q, wr_bank_n;
    logic              rd_bank_q, rd_bank_n;
    logic [ADDR_W-1:0] wptr_q, wptr_n;
    logic [ADDR_W-1:0] rptr_q, rptr_n;
    logic              in_ready_q, in_ready_n;
    logic              out_valid_q, out_valid_n;
    logic              out_last_q, out_last_n;
    logic [1:0]        full_mask_q, full_mask_n;
    logic [7:0]        frame_cnt_q, frame_cnt_n;
    logic              accept_c;
    logic              read_c;

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bank_q      <= {B_EMPTY, B_EMPTY};
            rd_state_q  <= R_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            full_mask_q <= 2'b00;
            frame_cnt_q <= 8'd0;
        end else begin
            bank_q      <= bank_n;
            rd_state_q  <= rd_state_n;
            wr_bank_q   <= wr_bank_n;
            rd_bank_q   <= rd_bank_n;
            wptr_q      <= wptr_n;
            rptr_q      <= rptr_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            out_last_q  <= out_last_n;
            full_mask_q <= full_mask_n;
            frame_cnt_q <= frame_cnt_n;
        end
    end

    // Writer, reader FSM and bank bookkeeping
    always_comb begin
        bank_n      = bank_q;
        rd_state_n  = rd_state_q;
        wr_bank_n   = wr_bank_q;
        rd_bank_n   = rd_bank_q;
        wptr_n      = wptr_q;
        rptr_n      = rptr_q;
        out_valid_n = 1'b0;
        out_last_n  = 1'b0;
        frame_cnt_n = frame_cnt_q;
        read_c      = 1'b0;
        accept_c    = in_valid && in_ready_q;

        if (accept_c) begin
            if (wptr_q == LAST_ADDR) begin
                bank_n[wr_bank_q] = B_FULL;
                wptr_n            = '0;
                wr_bank_n         = ~wr_bank_q;
            end else begin
                bank_n[wr_bank_q] = B_FILLING;
                wptr_n            = wptr_q + ADDR_W'(1);
            end
        end

        case (rd_state_q)
            R_IDLE: begin
                if (out_req && bank_q[rd_bank_q] == B_FULL) begin
                    bank_n[rd_bank_q] = B_DRAINING;
                    rptr_n            = '0;
                    rd_state_n        = R_READ;
                end
            end
            R_READ: begin
                read_c      = 1'b1;
                out_valid_n = 1'b1;
                if (rptr_q == LAST_ADDR) begin
                    out_last_n = 1'b1;
                    rptr_n     = '0;
                    rd_state_n = R_TAIL;
                end else begin
                    rptr_n = rptr_q + ADDR_W'(1);
                end
            end
            R_TAIL: begin
                bank_n[rd_bank_q] = B_EMPTY;
                rd_bank_n         = ~rd_bank_q;
                frame_cnt_n       = frame_cnt_q + 8'd1;
                rd_state_n        = R_IDLE;
            end
            default: rd_state_n = R_IDLE;
        endcase

        // Readiness and fullness track the bank states that take effect at this edge
        in_ready_n  = (bank_n[wr_bank_n] == B_EMPTY) || (bank_n[wr_bank_n] == B_FILLING);
        full_mask_n = {bank_n[1] == B_FULL, bank_n[0] == B_FULL};
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign full_mask  = full_mask_q;
    assign frame_cnt  = frame_cnt_q;

    // RAM ports are gated so idle buses stay at zero
    assign ram0_we    = accept_c && !wr_bank_q;
    assign ram1_we    = accept_c && wr_bank_q;
    assign ram0_waddr = ram0_we ? wptr_q : '0;
    assign ram1_waddr = ram1_we ? wptr_q : '0;
    assign ram0_wdata = ram0_we ? in_data : '0;
    assign ram1_wdata = ram1_we ? in_data : '0;
    assign ram0_re    = read_c && !rd_bank_q;
    assign ram1_re    = read_c && rd_bank_q;
    assign ram0_raddr = ram0_re ? rptr_q : '0;
    assign ram1_raddr = ram1_re ? rptr_q : '0;

    // rd_bank only toggles after the tail cycle, so it still selects the returning bank
    assign out_data   = out_valid_q ? (rd_bank_q ? ram1_rdata : ram0_rdata) : '0;

endmodule

// File: tb/tb_pingpong_buffer_ctrl.sv
// Directed bench for pingpong_buffer_ctrl with behavioural 32x8 RAMs (1-cycle read latency).
module tb_pingpong_buffer_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       out_req = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       ram0_we, ram1_we, ram0_re, ram1_re;
    logic [4:0] ram0_waddr, ram1_waddr, ram0_raddr, ram1_raddr;
    logic [7:0] ram0_wdata, ram1_wdata;
    logic [7:0] ram0_rdata, ram1_rdata;
    logic [1:0] full_mask;
    logic [7:0] frame_cnt;

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pingpong_buffer_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_req(out_req), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .ram0_we(ram0_we), .ram0_waddr(ram0_waddr), .ram0_wdata(ram0_wdata),
        .ram0_re(ram0_re), .ram0_raddr(ram0_raddr), .ram0_rdata(ram0_rdata),
        .ram1_we(ram1_we), .ram1_waddr(ram1_waddr), .ram1_wdata(ram1_wdata),
        .ram1_re(ram1_re), .ram1_raddr(ram1_raddr), .ram1_rdata(ram1_rdata),
        .full_mask(full_mask), .frame_cnt(frame_cnt)
    );

    always @(posedge clk) begin
        if (ram0_we) mem0[ram0_waddr] <= ram0_wdata;
        if (ram1_we) mem1[ram1_waddr] <= ram1_wdata;
        if (ram0_re) ram0_rdata <= mem0[ram0_raddr];
        if (ram1_re) ram1_rdata <= mem1[ram1_raddr];
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; in_valid = 1'b0; out_req = 1'b0; in_data = 8'd0;
        step(); step();
        resetn = 1'b1;
        step(); #1;
    endtask

    task automatic stream(input int n, input logic [7:0] first);
        int  sent = 0;
        int  guard = 0;
        logic acc;
        in_valid = 1'b1; in_data = first;
        while (sent < n && guard < 500) begin
            #1; acc = in_ready;
            step();
            if (acc) begin sent++; in_data = 8'(in_data + 8'd1); end
            guard++;
        end
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL stream_timeout: sent %0d words, expected %0d", sent, n);
        end
        in_valid = 1'b0; #1;
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!out_valid && g < 100) begin step(); #1; g++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_valid: out_valid never rose within 100 cycles", tag);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_req = 1'b1;
        step(); step(); #1;
        checks++;
        if ({in_ready, ram0_we, ram1_we, ram0_re, ram1_re, out_valid, out_last} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 0000000",
                     {in_ready, ram0_we, ram1_we, ram0_re, ram1_re, out_valid, out_last});
        end
        checks++;
        if (full_mask !== 2'b00 || frame_cnt !== 8'd0 || out_data !== 8'd0 || ram0_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: full_mask=%b frame_cnt=%0d out_data=%h wdata=%h, expected all 0",
                     full_mask, frame_cnt, out_data, ram0_wdata);
        end
        resetn = 1'b1; in_valid = 1'b0; out_req = 1'b0;
        step(); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_fill();
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 8'(i);
            #1;
            checks++;
            if (ram0_we !== 1'b1 || ram0_waddr !== 5'(i) || ram0_wdata !== 8'(i) || ram1_we !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_word%0d: we0=%b waddr=%0d wdata=%h we1=%b rdy=%b, expected 1 %0d %h 0 1",
                         i, ram0_we, ram0_waddr, ram0_wdata, ram1_we, in_ready, i, 8'(i));
            end
            step();
        end
        in_valid = 1'b0; #1;
        checks++;
        if (full_mask !== 2'b01 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_done: full_mask=%b in_ready=%b, expected 01 1", full_mask, in_ready);
        end
    endtask

    task automatic test_stall();
        do_reset();
        stream(64, 8'h00);
        in_valid = 1'b1; in_data = 8'h40;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (full_mask !== 2'b11 || in_ready !== 1'b0 || ram0_we !== 1'b0 || ram1_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_c%0d: full_mask=%b rdy=%b we0=%b we1=%b, expected 11 0 0 0",
                         c, full_mask, in_ready, ram0_we, ram1_we);
            end
            step();
        end
    endtask

    task automatic test_drain();
        out_req = 1'b1;
        wait_valid("drain");
        out_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || out_last !== (k == 31)) begin
                errors++;
                $display("FAIL drain_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         k, out_valid, out_data, out_last, 8'(k), (k == 31));
            end
            if (k == 31) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_tail_ready: in_ready=%b, expected 0", in_ready);
                end
            end
            step(); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'd1 || in_ready !== 1'b1 || full_mask !== 2'b10) begin
            errors++;
            $display("FAIL drain_done: valid=%b cnt=%0d rdy=%b mask=%b, expected 0 1 1 10",
                     out_valid, frame_cnt, in_ready, full_mask);
        end
        checks++;
        if (ram0_we !== 1'b1 || ram0_waddr !== 5'd0 || ram0_wdata !== 8'h40 || ram1_we !== 1'b0) begin
            errors++;
            $display("FAIL drain_rewrite: we0=%b waddr=%0d wdata=%h we1=%b, expected 1 0 40 0",
                     ram0_we, ram0_waddr, ram0_wdata, ram1_we);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_continuous();
        logic [7:0] exp_word;
        int         words;
        logic       acc;
        do_reset();
        exp_word = 8'd0; words = 0;
        out_req = 1'b1; in_valid = 1'b1; in_data = 8'd0;
        for (int c = 0; c < 3000; c++) begin
            #1;
            acc = in_ready;
            checks++;
            if ((ram0_we && ram0_re) || (ram1_we && ram1_re)) begin
                errors++;
                $display("FAIL cont_overlap: cycle %0d we0=%b re0=%b we1=%b re1=%b", c, ram0_we, ram0_re, ram1_we, ram1_re);
            end
            if (out_valid) begin
                checks++;
                if (out_data !== exp_word || out_last !== (exp_word[4:0] == 5'd31)) begin
                    errors++;
                    $display("FAIL cont_word%0d: data=%h last=%b, expected %h %b",
                             words, out_data, out_last, exp_word, (exp_word[4:0] == 5'd31));
                end
                exp_word = 8'(exp_word + 8'd1);
                words++;
            end
            if (frame_cnt == 8'd10) break;
            step();
            if (acc) in_data = 8'(in_data + 8'd1);
        end
        checks++;
        if (frame_cnt !== 8'd10 || words != 320) begin
            errors++;
            $display("FAIL cont_frames: frame_cnt=%0d words=%0d, expected 10 320", frame_cnt, words);
        end
        out_req = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        stream(32, 8'h00);
        out_req = 1'b1;
        wait_valid("rstmid");
        for (int k = 0; k < 10; k++) begin step(); #1; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd10) begin
            errors++;
            $display("FAIL rstmid_word10: valid=%b data=%h, expected 1 0a", out_valid, out_data);
        end
        resetn = 1'b0; out_req = 1'b0;
        step(); #1;
        checks++;
        if (out_valid !== 1'b0 || full_mask !== 2'b00 || in_ready !== 1'b0 || frame_cnt !== 8'd0 || ram0_re !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: valid=%b mask=%b rdy=%b cnt=%0d re0=%b, expected 0 00 0 0 0",
                     out_valid, full_mask, in_ready, frame_cnt, ram0_re);
        end
        resetn = 1'b1;
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 8'(8'hA0 + i);
            #1;
            checks++;
            if (ram0_we !== 1'b1 || ram0_waddr !== 5'(i) || ram0_wdata !== 8'(8'hA0 + i) || ram1_we !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_refill%0d: we0=%b waddr=%0d wdata=%h we1=%b, expected 1 %0d %h 0",
                         i, ram0_we, ram0_waddr, ram0_wdata, ram1_we, i, 8'(8'hA0 + i));
            end
            step();
        end
        in_valid = 1'b0; #1;
        checks++;
        if (full_mask !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_mask: full_mask=%b, expected 01", full_mask);
        end
    endtask

    task automatic test_pulse();
        logic seen;
        do_reset();
        stream(64, 8'h00);
        out_req = 1'b1;
        step();
        out_req = 1'b0; #1;
        wait_valid("pulse1");
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || out_last !== (k == 31)) begin
                errors++;
                $display("FAIL pulse_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         k, out_valid, out_data, out_last, 8'(k), (k == 31));
            end
            step(); #1;
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen = 1'b1;
            step(); #1;
        end
        checks++;
        if (seen !== 1'b0 || frame_cnt !== 8'd1 || full_mask !== 2'b10) begin
            errors++;
            $display("FAIL pulse_hold: out_valid_seen=%b cnt=%0d mask=%b, expected 0 1 10", seen, frame_cnt, full_mask);
        end
        out_req = 1'b1;
        wait_valid("pulse2");
        out_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(32 + k) || out_last !== (k == 31)) begin
                errors++;
                $display("FAIL pulse2_word%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                         k, out_valid, out_data, out_last, 8'(32 + k), (k == 31));
            end
            step(); #1;
        end
        checks++;
        if (frame_cnt !== 8'd2 || full_mask !== 2'b00) begin
            errors++;
            $display("FAIL pulse2_done: cnt=%0d mask=%b, expected 2 00", frame_cnt, full_mask);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_drain();
        test_continuous();
        test_reset_mid();
        test_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
